xydb_arbiter: RTL and testbench



---
 rtl/xydb_arbiter_pkg.sv | 44 ++++
 rtl/xydb_arbiter_bus_arb.sv | 123 ++++++++++++
 rtl/xydb_arbiter.sv | 109 ++++++++++
 tb/tb_xydb_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/xydb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// xydb_arbiter_pkg
// Shared definitions for the XDB/YDB write-ownership arbiter: per-bus FSM
// state encoding, requester indices, the "no owner" code, default limits
// and a few small helpers used by the top level and the per-bus arbiter.
// ---------------------------------------------------------------------------
package xydb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CORE  = 2'd1,
    LOW   = 2'd2,
    FORCE = 2'd3
  } arb_state_e;

  localparam logic [1:0] REQ_CORE   = 2'd0;
  localparam logic [1:0] REQ_PERIPH = 2'd1;
  localparam logic [1:0] REQ_HOST   = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'b11;

  localparam int STARVE_MAX_DEF = 4;
  localparam int MAX_LOCK_DEF   = 8;

  // Requester index to one-hot grant; OWNER_NONE maps to no grant.
  function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
    case (idx)
      REQ_CORE:   return 3'b001;
      REQ_PERIPH: return 3'b010;
      REQ_HOST:   return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  // The low-priority requester that is not idx.
  function automatic logic [1:0] other_low(input logic [1:0] idx);
    return (idx == REQ_PERIPH) ? REQ_HOST : REQ_PERIPH;
  endfunction

  // True when two or more requesters contend for the same bus.
  function automatic logic multi_req(input logic [2:0] req);
    return (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);
  endfunction

endpackage

// File: rtl/xydb_arbiter_bus_arb.sv
// ---------------------------------------------------------------------------
// xydb_arbiter_bus_arb (the bus_arb sub-block)
// Single-bus write arbiter: core priority, round-robin between the
// peripheral and host requesters, burst lock with a length cap, and a
// starvation guard that force-grants a waiting low requester for one cycle.
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   req_i[2:0] requests, bit i = requester i
//   lock_i[2:0] burst-lock hints, only bits 1 and 2 matter
//   gnt_o[2:0] registered one-hot (or zero) grant
//   owner_o    registered owner index, OWNER_NONE when idle
//   force_d_o  next-cycle force flag, registered by the top as core stall
// ---------------------------------------------------------------------------
module xydb_arbiter_bus_arb
  import xydb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int MAX_LOCK   = MAX_LOCK_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] req_i,
  input  logic [2:0] lock_i,
  output logic [2:0] gnt_o,
  output logic [1:0] owner_o,
  output logic       force_d_o
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
  localparam logic [3:0] MaxLock   = 4'(MAX_LOCK);

  arb_state_e state_q, state_d;
  logic [2:0] gnt_q, gnt_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] starve_q, starve_d;
  logic [3:0] lock_q, lock_d;
  logic       force_d;

  logic       low_pend;
  logic [1:0] rr_win;
  logic       own_req;
  logic       own_lock;

  // The core cannot lock a bus, so its hint bit is intentionally dropped.
  logic       unused_lock0;
  assign unused_lock0 = lock_i[0];

  // Round-robin winner among the low requesters and the current owner's
  // request/lock bits, used by the lock-hold decision.
  always_comb begin
    low_pend = req_i[1] | req_i[2];
    rr_win   = REQ_PERIPH;
    if (req_i[1] && req_i[2]) begin
      rr_win = ptr_q;
    end else if (req_i[2]) begin
      rr_win = REQ_HOST;
    end
    own_req  = (owner_q == REQ_HOST) ? req_i[2]  : req_i[1];
    own_lock = (owner_q == REQ_HOST) ? lock_i[2] : lock_i[1];
  end

  // Next-state decision in precedence order: starvation force, core,
  // lock hold, fresh low grant, idle. Anything that gives a low requester
  // the bus clears the starvation count; only a core grant with a low
  // request waiting advances it.
  always_comb begin
    state_d  = IDLE;
    owner_d  = OWNER_NONE;
    force_d  = 1'b0;
    ptr_d    = ptr_q;
    starve_d = 4'd0;
    lock_d   = 4'd0;
    if (low_pend && (starve_q == StarveMax)) begin
      state_d = FORCE;
      owner_d = rr_win;
      force_d = 1'b1;
      ptr_d   = other_low(rr_win);
    end else if (req_i[0]) begin
      state_d = CORE;
      owner_d = REQ_CORE;
      if (low_pend) begin
        starve_d = (starve_q < StarveMax) ? starve_q + 4'd1 : starve_q;
      end
    end else if ((state_q == LOW) && own_req && own_lock && (lock_q < MaxLock)) begin
      state_d = LOW;
      owner_d = owner_q;
      lock_d  = lock_q + 4'd1;
    end else if (low_pend) begin
      state_d = LOW;
      owner_d = rr_win;
      ptr_d   = other_low(rr_win);
      lock_d  = 4'd1;
    end
    gnt_d = idx_to_onehot(owner_d);
  end

  // All arbiter state, including the grant outputs, lives in these flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      gnt_q    <= 3'b000;
      owner_q  <= OWNER_NONE;
      ptr_q    <= REQ_PERIPH;
      starve_q <= 4'd0;
      lock_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      starve_q <= starve_d;
      lock_q   <= lock_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign owner_o   = owner_q;
  assign force_d_o = force_d;

endmodule

// File: rtl/xydb_arbiter.sv
// ---------------------------------------------------------------------------
// xydb_arbiter
// Arbitrates write ownership of the X and Y data buses between the core
// (requester 0), the peripheral port (1) and the host/debug port (2).
// Two identical bus arbiters run side by side; their force flags are
// merged into a single registered core stall, so simultaneous forces on
// both buses cost the core only one cycle.
//
// Ports:
//   Clk, reset_n          clock and asynchronous active-low reset
//   x_req/x_lock [2:0]    XDB requests and lock hints
//   x_gnt [2:0], x_owner  XDB registered grant and owner (2'b11 = none)
//   y_req/y_lock [2:0]    YDB requests and lock hints
//   y_gnt [2:0], y_owner  YDB registered grant and owner (2'b11 = none)
//   core_stall            registered, high in any force cycle
//   x_conflicts, y_conflicts [15:0]  saturating contention counters,
//                         present only when XYDB_ARB_STATS_EN is defined
// ---------------------------------------------------------------------------
module xydb_arbiter
  import xydb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int MAX_LOCK   = MAX_LOCK_DEF
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic [2:0]  x_req,
  input  logic [2:0]  x_lock,
  output logic [2:0]  x_gnt,
  input  logic [2:0]  y_req,
  input  logic [2:0]  y_lock,
  output logic [2:0]  y_gnt,
  output logic        core_stall,
  output logic [1:0]  x_owner,
  output logic [1:0]  y_owner
`ifdef XYDB_ARB_STATS_EN
  ,
  output logic [15:0] x_conflicts,
  output logic [15:0] y_conflicts
`endif
);

  logic x_force_d;
  logic y_force_d;
  logic core_stall_q;

  xydb_arbiter_bus_arb #(
    .STARVE_MAX(STARVE_MAX),
    .MAX_LOCK  (MAX_LOCK)
  ) u_bus_arb_x (
    .clk_i    (Clk),
    .rst_ni   (reset_n),
    .req_i    (x_req),
    .lock_i   (x_lock),
    .gnt_o    (x_gnt),
    .owner_o  (x_owner),
    .force_d_o(x_force_d)
  );

  xydb_arbiter_bus_arb #(
    .STARVE_MAX(STARVE_MAX),
    .MAX_LOCK  (MAX_LOCK)
  ) u_bus_arb_y (
    .clk_i    (Clk),
    .rst_ni   (reset_n),
    .req_i    (y_req),
    .lock_i   (y_lock),
    .gnt_o    (y_gnt),
    .owner_o  (y_owner),
    .force_d_o(y_force_d)
  );

  // The stall is registered from the next-cycle force flags so it rises
  // in exactly the cycle the forced low grant is visible on either bus.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      core_stall_q <= 1'b0;
    end else begin
      core_stall_q <= x_force_d | y_force_d;
    end
  end

  assign core_stall = core_stall_q;

`ifdef XYDB_ARB_STATS_EN
  logic [15:0] x_conf_q;
  logic [15:0] y_conf_q;

  // Contention counters: one count per cycle with two or more requests on
  // the bus, holding at all-ones instead of wrapping.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      x_conf_q <= 16'd0;
      y_conf_q <= 16'd0;
    end else begin
      if (multi_req(x_req) && (x_conf_q != 16'hFFFF)) begin
        x_conf_q <= x_conf_q + 16'd1;
      end
      if (multi_req(y_req) && (y_conf_q != 16'hFFFF)) begin
        y_conf_q <= y_conf_q + 16'd1;
      end
    end
  end

  assign x_conflicts = x_conf_q;
  assign y_conflicts = y_conf_q;
`endif

endmodule

// File: tb/tb_xydb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xydb_arbiter
// Directed bench for xydb_arbiter with default limits (STARVE_MAX = 4,
// MAX_LOCK = 8). Each step drives both buses, records the grants it
// expects one edge later, then compares them with the registered outputs.
// ---------------------------------------------------------------------------
module tb_xydb_arbiter;

  logic       Clk;
  logic       reset_n;
  logic [2:0] x_req, x_lock, x_gnt;
  logic [2:0] y_req, y_lock, y_gnt;
  logic       core_stall;
  logic [1:0] x_owner, y_owner;
`ifdef XYDB_ARB_STATS_EN
  logic [15:0] x_conflicts, y_conflicts;
`endif

  typedef struct {
    string      tag;
    logic [2:0] xGnt;
    logic [2:0] yGnt;
    logic       stall;
  } expect_t;

  expect_t sbQueue[$];
  int      nAsserts = 0;
  int      nFail    = 0;
  int      expXConf = 0;
  int      expYConf = 0;

  xydb_arbiter dut (
    .Clk       (Clk),
    .reset_n   (reset_n),
    .x_req     (x_req),
    .x_lock    (x_lock),
    .x_gnt     (x_gnt),
    .y_req     (y_req),
    .y_lock    (y_lock),
    .y_gnt     (y_gnt),
    .core_stall(core_stall),
    .x_owner   (x_owner),
    .y_owner   (y_owner)
`ifdef XYDB_ARB_STATS_EN
    ,
    .x_conflicts(x_conflicts),
    .y_conflicts(y_conflicts)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Owner index expected for a given one-hot grant, zero-extended.
  function automatic logic [2:0] ownerOf(input logic [2:0] g);
    case (g)
      3'b001:  return 3'd0;
      3'b010:  return 3'd1;
      3'b100:  return 3'd2;
      default: return 3'd3;
    endcase
  endfunction

  function automatic int countBits(input logic [2:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]);
  endfunction

  task automatic cmp(input string tag, input string what,
                     input logic [2:0] obs, input logic [2:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s %s observed=%b expected=%b", tag, what, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare every output against it.
  task automatic checkOutput();
    expect_t e;
    nAsserts++;
    assert (sbQueue.size() != 0) else begin
      nFail++;
      $error("[TB] FAIL scoreboard_empty observed=%0d expected=1", sbQueue.size());
    end
    if (sbQueue.size() != 0) begin
      e = sbQueue.pop_front();
      cmp(e.tag, "x_gnt", x_gnt, e.xGnt);
      cmp(e.tag, "y_gnt", y_gnt, e.yGnt);
      cmp(e.tag, "x_owner", {1'b0, x_owner}, ownerOf(e.xGnt));
      cmp(e.tag, "y_owner", {1'b0, y_owner}, ownerOf(e.yGnt));
      cmp(e.tag, "core_stall", {2'b00, core_stall}, {2'b00, e.stall});
    end
  endtask

  task automatic pushExpect(input string tag, input logic [2:0] eX,
                            input logic [2:0] eY, input logic eS);
    expect_t e;
    e.tag   = tag;
    e.xGnt  = eX;
    e.yGnt  = eY;
    e.stall = eS;
    sbQueue.push_back(e);
  endtask

  // Drive one cycle of requests, record what must appear after the next
  // edge, then sample one time unit past that edge.
  task automatic applyStimulus(input string tag,
                               input logic [2:0] xr, input logic [2:0] xl,
                               input logic [2:0] yr, input logic [2:0] yl,
                               input logic [2:0] eX, input logic [2:0] eY,
                               input logic eS);
    x_req  = xr;
    x_lock = xl;
    y_req  = yr;
    y_lock = yl;
    pushExpect(tag, eX, eY, eS);
    @(posedge Clk);
    if (countBits(xr) >= 2) expXConf++;
    if (countBits(yr) >= 2) expYConf++;
    #1;
    checkOutput();
  endtask

  initial begin
    reset_n = 1'b0;
    x_req = 3'b000; x_lock = 3'b000;
    y_req = 3'b000; y_lock = 3'b000;
    $display("[TB] start");

    // Reset state while reset_n is held low.
    repeat (3) @(posedge Clk);
    #1;
    pushExpect("in_reset", 3'b000, 3'b000, 1'b0);
    checkOutput();
    reset_n = 1'b1;

    // Idle after reset release.
    for (int i = 0; i < 10; i++)
      applyStimulus("idle", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

    // Round robin on X starting at the peripheral.
    for (int i = 0; i < 3; i++) begin
      applyStimulus("rr_a", 3'b110, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 1'b0);
      applyStimulus("rr_b", 3'b110, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 1'b0);
    end
    applyStimulus("rr_end", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

    // Peripheral locks X: held for MAX_LOCK cycles, then host gets it.
    for (int i = 0; i < 8; i++)
      applyStimulus("lock_hold", 3'b110, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 1'b0);
    applyStimulus("lock_cap", 3'b110, 3'b010, 3'b000, 3'b000, 3'b100, 3'b000, 1'b0);
    applyStimulus("lock_end", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

    // Starvation on X: four core cycles, one forced peripheral cycle.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++)
        applyStimulus("starve_core", 3'b011, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 1'b0);
      applyStimulus("starve_force", 3'b011, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 1'b1);
    end
    applyStimulus("starve_after", 3'b011, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 1'b0);
    applyStimulus("starve_end", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

    // Core preempts a locked host on Y; lock on bit 0 is ignored.
    applyStimulus("pre_host", 3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b100, 1'b0);
    applyStimulus("pre_hold", 3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b100, 1'b0);
    applyStimulus("pre_core", 3'b000, 3'b000, 3'b101, 3'b100, 3'b000, 3'b001, 1'b0);
    applyStimulus("pre_core2", 3'b000, 3'b000, 3'b101, 3'b100, 3'b000, 3'b001, 1'b0);
    applyStimulus("pre_back", 3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b100, 1'b0);
    applyStimulus("pre_drop", 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 1'b0);
    applyStimulus("core_lock", 3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b001, 1'b0);
    applyStimulus("core_drop", 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 1'b0);

    // Both buses starve together: a single stall cycle.
    for (int i = 0; i < 4; i++)
      applyStimulus("dual_core", 3'b011, 3'b000, 3'b101, 3'b000, 3'b001, 3'b001, 1'b0);
    applyStimulus("dual_force", 3'b011, 3'b000, 3'b101, 3'b000, 3'b010, 3'b100, 1'b1);
    applyStimulus("dual_after", 3'b011, 3'b000, 3'b101, 3'b000, 3'b001, 3'b001, 1'b0);
    applyStimulus("dual_end", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

`ifdef XYDB_ARB_STATS_EN
    cmp("stats", "x_conflicts_lo", x_conflicts[2:0], 3'(expXConf));
    cmp("stats", "y_conflicts_lo", y_conflicts[2:0], 3'(expYConf));
`endif

    // Peripheral burst, then asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++)
      applyStimulus("burst", 3'b010, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    pushExpect("async_reset", 3'b000, 3'b000, 1'b0);
    checkOutput();
    expXConf = 0;
    expYConf = 0;
    x_req = 3'b000; x_lock = 3'b000;
    @(posedge Clk);
    #1;
    pushExpect("reset_held", 3'b000, 3'b000, 1'b0);
    checkOutput();
    reset_n = 1'b1;

    // Pointer is back on the peripheral after reset.
    applyStimulus("post_reset", 3'b110, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 1'b0);
    applyStimulus("post_end", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
